// File: rtl/fetch_byte_pkg.sv
// Shared types for the word-fetch / byte-serialise block.
// State encoding and lane index live here so neighbours can reuse them.
package fetch_byte_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_LOAD,
    S_SEND,
    S_TXHI,
    S_TXLO,
    S_NEXT,
    S_DONE
  } state_e;

  typedef logic [1:0] lane_t;

  localparam lane_t LANE_FIRST = 2'd0;
  localparam lane_t LANE_LAST  = 2'd3;

endpackage

// File: rtl/fetch_byte.sv
// Reads 32-bit words from memory and streams them, low byte
// first, to a UART transmitter using a tx_start/tx_busy handshake.
module fetch_byte
  import fetch_byte_pkg::*;
#(
  parameter int unsigned BYTES     = 36,
  parameter logic [15:0] BASE_ADDR = 16'd0,
  parameter int unsigned RD_LAT    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        rd_en,
  output logic [15:0] address,
  input  logic [31:0] mem_data,
  input  logic        tx_busy,
  output logic        tx_start,
  output logic [7:0]  tx_byte,
  output logic        done
);

  localparam logic [16:0] LAST_BYTE = 17'(BYTES - 1);
  localparam logic [1:0]  WAIT_LAST =
    2'(RD_LAT >= 2 ? RD_LAT - 2 : 0);
  localparam logic [15:0] FIRST_ADDR = BASE_ADDR + 16'd1;

  state_e      state_q, state_d;
  logic [1:0]  wait_q, wait_d;
  logic [31:0] word_q, word_d;
  lane_t       lane_q, lane_d;
  logic [16:0] cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d;
  logic        rd_en_q, rd_en_d;
  logic        tx_start_q, tx_start_d;
  logic [7:0]  tx_byte_q, tx_byte_d;
  logic        done_q, done_d;

  logic [31:0] mux_word;
  lane_t       mux_lane;
  logic [7:0]  sel_byte;

  // Lane 0 comes straight from memory in LOAD; later lanes
  // come from the captured word, one lane ahead of lane_q.
  always_comb begin
    mux_word = word_q;
    mux_lane = lane_q + 2'd1;
    if (state_q == S_LOAD) begin
      mux_word = mem_data;
      mux_lane = LANE_FIRST;
    end
  end

  always_comb begin
    sel_byte = 8'd0;
    unique case (mux_lane)
      2'd0: sel_byte = mux_word[7:0];
      2'd1: sel_byte = mux_word[15:8];
      2'd2: sel_byte = mux_word[23:16];
      2'd3: sel_byte = mux_word[31:24];
      default: sel_byte = 8'd0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    word_d     = word_q;
    lane_d     = lane_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    rd_en_d    = 1'b0;
    tx_start_d = 1'b0;
    tx_byte_d  = tx_byte_q;
    done_d     = done_q;
    unique case (state_q)
      S_IDLE: begin
        if (start && !tx_busy) begin
          state_d = S_READ;
          addr_d  = FIRST_ADDR;
          cnt_d   = '0;
          lane_d  = LANE_FIRST;
          rd_en_d = 1'b1;
        end
      end
      S_READ: begin
        wait_d = '0;
        if (RD_LAT <= 1) begin
          state_d = S_LOAD;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (wait_q == WAIT_LAST) begin
          state_d = S_LOAD;
        end else begin
          wait_d = wait_q + 2'd1;
        end
      end
      S_LOAD: begin
        word_d     = mem_data;
        lane_d     = LANE_FIRST;
        tx_byte_d  = sel_byte;
        tx_start_d = 1'b1;
        state_d    = S_SEND;
      end
      S_SEND: begin
        state_d = S_TXHI;
      end
      S_TXHI: begin
        if (tx_busy) begin
          state_d = S_TXLO;
        end
      end
      S_TXLO: begin
        if (!tx_busy) begin
          state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        cnt_d = cnt_q + 17'd1;
        if (cnt_q == LAST_BYTE) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else if (lane_q == LANE_LAST) begin
          addr_d  = addr_q + 16'd1;
          rd_en_d = 1'b1;
          state_d = S_READ;
        end else begin
          lane_d     = lane_q + 2'd1;
          tx_byte_d  = sel_byte;
          tx_start_d = 1'b1;
          state_d    = S_SEND;
        end
      end
      S_DONE: begin
        if (start) begin
          done_d  = 1'b0;
          addr_d  = FIRST_ADDR;
          cnt_d   = '0;
          lane_d  = LANE_FIRST;
          rd_en_d = 1'b1;
          state_d = S_READ;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wait_q     <= '0;
      word_q     <= '0;
      lane_q     <= '0;
      cnt_q      <= '0;
      addr_q     <= BASE_ADDR;
      rd_en_q    <= 1'b0;
      tx_start_q <= 1'b0;
      tx_byte_q  <= 8'd0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      word_q     <= word_d;
      lane_q     <= lane_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      rd_en_q    <= rd_en_d;
      tx_start_q <= tx_start_d;
      tx_byte_q  <= tx_byte_d;
      done_q     <= done_d;
    end
  end

  assign rd_en    = rd_en_q;
  assign address  = addr_q;
  assign tx_start = tx_start_q;
  assign tx_byte  = tx_byte_q;
  assign done     = done_q;

endmodule

// File: tb/tb_fetch_byte.sv
// Four fetch_byte configurations driven against memory/UART models,
// with expected byte streams computed from the memory image.
module tb_fetch_byte;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start [4];
  logic        rd_en [4];
  logic [15:0] address [4];
  logic [31:0] mem_data [4];
  logic        tx_busy [4];
  logic        tx_start [4];
  logic [7:0]  tx_byte [4];
  logic        done [4];

  logic [31:0] mem [4][64];
  logic [31:0] pipe [4][3];
  int          bcnt [4];
  int          busy_len [4];

  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;

  logic [7:0]  obs_b [4][64];
  logic [15:0] obs_a [4][32];
  logic [7:0]  last_b [4];
  int          n_tx [4];
  int          n_rd [4];
  int          first_tx [4];
  int          hz_err [4];
  int          stab_err [4];

  always #5 clk = ~clk;

  fetch_byte u0 (
    .clk(clk), .rst(rst), .start(start[0]), .rd_en(rd_en[0]),
    .address(address[0]), .mem_data(mem_data[0]),
    .tx_busy(tx_busy[0]), .tx_start(tx_start[0]),
    .tx_byte(tx_byte[0]), .done(done[0])
  );

  fetch_byte #(.BYTES(6), .BASE_ADDR(16'd0), .RD_LAT(2)) u1 (
    .clk(clk), .rst(rst), .start(start[1]), .rd_en(rd_en[1]),
    .address(address[1]), .mem_data(mem_data[1]),
    .tx_busy(tx_busy[1]), .tx_start(tx_start[1]),
    .tx_byte(tx_byte[1]), .done(done[1])
  );

  fetch_byte #(.BYTES(8), .BASE_ADDR(16'hFFFF), .RD_LAT(3)) u2 (
    .clk(clk), .rst(rst), .start(start[2]), .rd_en(rd_en[2]),
    .address(address[2]), .mem_data(mem_data[2]),
    .tx_busy(tx_busy[2]), .tx_start(tx_start[2]),
    .tx_byte(tx_byte[2]), .done(done[2])
  );

  fetch_byte #(.BYTES(4), .BASE_ADDR(16'd0), .RD_LAT(1)) u3 (
    .clk(clk), .rst(rst), .start(start[3]), .rd_en(rd_en[3]),
    .address(address[3]), .mem_data(mem_data[3]),
    .tx_busy(tx_busy[3]), .tx_start(tx_start[3]),
    .tx_byte(tx_byte[3]), .done(done[3])
  );

  function automatic int nb(input int i);
    case (i)
      0: return 36;
      1: return 6;
      2: return 8;
      default: return 4;
    endcase
  endfunction

  function automatic logic [15:0] base(input int i);
    return (i == 2) ? 16'hFFFF : 16'h0000;
  endfunction

  function automatic int lat(input int i);
    case (i)
      1: return 2;
      2: return 3;
      default: return 1;
    endcase
  endfunction

  // Memory with per-instance read latency; non-read cycles push junk.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      pipe[i][2] <= pipe[i][1];
      pipe[i][1] <= pipe[i][0];
      pipe[i][0] <= rd_en[i] ? mem[i][address[i][5:0]] : $urandom;
    end
  end

  assign mem_data[0] = pipe[0][0];
  assign mem_data[1] = pipe[1][1];
  assign mem_data[2] = pipe[2][2];
  assign mem_data[3] = pipe[3][0];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 4; i++) begin
      if (tx_start[i]) bcnt[i] <= busy_len[i];
      else if (bcnt[i] > 0) bcnt[i] <= bcnt[i] - 1;
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_busy
    assign tx_busy[g] = (bcnt[g] != 0);
  end

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (tx_busy[i] && (tx_start[i] || tx_byte[i] !== last_b[i]))
        stab_err[i]++;
      if (tx_start[i]) begin
        if (n_tx[i] < 64) obs_b[i][n_tx[i]] = tx_byte[i];
        if (first_tx[i] < 0) first_tx[i] = cyc;
        last_b[i] = tx_byte[i];
        n_tx[i]++;
      end
      if (rd_en[i]) begin
        if (n_rd[i] < 32) obs_a[i][n_rd[i]] = address[i];
        n_rd[i]++;
      end
      if (rd_en[i] && tx_start[i]) hz_err[i]++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon(input int i);
    n_tx[i] = 0;
    n_rd[i] = 0;
    first_tx[i] = -1;
    hz_err[i] = 0;
    stab_err[i] = 0;
  endtask

  task automatic run(input int i, input int bl);
    int k;
    int sc;
    int nw;
    logic [15:0] a;
    logic [31:0] w;
    busy_len[i] = bl;
    k = 0;
    while (tx_busy[i] && k < 2000) begin
      @(posedge clk); #1; k++;
    end
    clear_mon(i);
    @(negedge clk);
    start[i] = 1'b1;
    @(posedge clk); #1;
    sc = cyc;
    start[i] = 1'b0;
    k = 0;
    while (!done[i] && k < 20000) begin
      @(posedge clk); #1; k++;
    end
    chk($sformatf("u%0d done", i), done[i], 1);
    chk($sformatf("u%0d busy_at_done", i), tx_busy[i], 0);
    chk($sformatf("u%0d latency", i), first_tx[i] - sc + 1, lat(i) + 2);
    chk($sformatf("u%0d tx_count", i), n_tx[i], nb(i));
    for (int j = 0; j < nb(i) && j < n_tx[i] && j < 64; j++) begin
      a = base(i) + 16'(1 + j / 4);
      w = mem[i][a[5:0]] >> (8 * (j % 4));
      chk($sformatf("u%0d byte%0d", i, j), obs_b[i][j], w[7:0]);
    end
    nw = (nb(i) + 3) / 4;
    chk($sformatf("u%0d rd_count", i), n_rd[i], nw);
    for (int j = 0; j < nw && j < n_rd[i] && j < 32; j++) begin
      a = base(i) + 16'(1 + j);
      chk($sformatf("u%0d rd_addr%0d", i, j), obs_a[i][j], a);
    end
    chk($sformatf("u%0d rd_tx_overlap", i), hz_err[i], 0);
    chk($sformatf("u%0d tx_stable", i), stab_err[i], 0);
  endtask

  initial begin
    int k;
    for (int i = 0; i < 4; i++) begin
      start[i] = 1'b1;
      bcnt[i] = 0;
      busy_len[i] = 3;
      last_b[i] = 8'd0;
      clear_mon(i);
      for (int j = 0; j < 64; j++) mem[i][j] = $urandom;
    end
    mem[3][1] = 32'h44332211;
    mem[1][1] = 32'hDDCCBBAA;
    mem[1][2] = 32'h0000FFEE;

    // reset wins over a simultaneous start
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("u%0d rst rd_en", i), rd_en[i], 0);
      chk($sformatf("u%0d rst tx_start", i), tx_start[i], 0);
      chk($sformatf("u%0d rst done", i), done[i], 0);
      chk($sformatf("u%0d rst tx_byte", i), tx_byte[i], 0);
      chk($sformatf("u%0d rst address", i), address[i], base(i));
      start[i] = 1'b0;
    end
    @(negedge clk);
    rst = 1'b0;

    run(3, 10);
    run(1, $urandom_range(1, 12));
    run(2, $urandom_range(1, 12));
    run(0, $urandom_range(1, 12));

    // restart straight from DONE
    chk("u1 done_before_restart", done[1], 1);
    run(1, $urandom_range(1, 12));

    // abort mid-run after the second byte is launched
    for (int j = 0; j < 64; j++) mem[0][j] = $urandom;
    busy_len[0] = 6;
    clear_mon(0);
    @(negedge clk);
    start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    k = 0;
    while (n_tx[0] < 2 && k < 2000) begin
      @(posedge clk); #1; k++;
    end
    chk("u0 second_tx_seen", n_tx[0], 2);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("u0 abort rd_en", rd_en[0], 0);
    chk("u0 abort tx_start", tx_start[0], 0);
    chk("u0 abort address", address[0], 0);
    chk("u0 abort done", done[0], 0);
    repeat (30) @(posedge clk);
    #1;
    chk("u0 abort no_more_tx", n_tx[0], 2);
    chk("u0 abort no_more_rd", n_rd[0], 1);
    run(0, $urandom_range(1, 12));

    // transmitter stuck busy for a long time
    run(3, 200);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
